dual_mode_stack: RTL

//   Parametrised on-chip buffer for the board test circuits, selectable as LIFO (stack) or FIFO (queue).

---
 rtl/dual_mode_stack.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/dual_mode_stack.sv
// dual_mode_stack
//   Small on-chip word buffer that behaves either as a LIFO (stack) or a FIFO
//   (queue). It tracks occupancy and raises sticky overflow/underflow flags.
//   A synchronous clear flushes the contents, and simultaneous push+pop has a
//   defined result.
//
// Parameters
//   B  data word width in bits
//   W  address bits; depth = 2**W words
//
// Ports
//   clk      in   1    system clock, rising edge
//   reset_n  in   1    asynchronous active-low reset
//   push     in   1    write request (one-cycle pulse)
//   pop      in   1    remove request (one-cycle pulse)
//   mode     in   1    requested mode: 0 = LIFO, 1 = FIFO (takes effect only when empty)
//   clear    in   1    synchronous flush of contents and error flags
//   w_data   in   B    word written on push
//   r_data   out  B    top (LIFO) / head (FIFO) word, 0 when empty
//   count    out  W+1  number of stored words
//   full     out  1    count == 2**W
//   empty    out  1    count == 0
//   err_ovf  out  1    sticky: a push was refused because the buffer was full
//   err_unf  out  1    sticky: a pop was refused because the buffer was empty
//
// Request semantics: push and pop are single-cycle requests sampled on the
// rising edge. There is no back-pressure: a request that cannot be honoured
// (push when full, pop when empty) is dropped and latched in the matching
// sticky error flag. r_data is fall-through and reflects the state after the
// last accepting edge.

module dual_mode_stack #(
    parameter int B = 8,
    parameter int W = 2
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         push,
    input  logic         pop,
    input  logic         mode,
    input  logic         clear,
    input  logic [B-1:0] w_data,
    output logic [B-1:0] r_data,
    output logic [W:0]   count,
    output logic         full,
    output logic         empty,
    output logic         err_ovf,
    output logic         err_unf
);

    localparam int           DEPTH     = 1 << W;
    localparam logic [W:0]   DEPTH_CNT = {1'b1, {W{1'b0}}};

    logic [B-1:0] mem [DEPTH];

    logic [W-1:0] wr_ptr;
    logic [W-1:0] rd_ptr;
    logic         mode_q;

    logic [W-1:0] wr_ptr_n;
    logic [W-1:0] rd_ptr_n;
    logic [W:0]   count_n;
    logic         err_ovf_n;
    logic         err_unf_n;
    logic         we;
    logic [W-1:0] waddr;

    logic         mode_eff;
    logic         lifo;
    logic [W-1:0] top_addr;

    assign full  = (count == DEPTH_CNT);
    assign empty = (count == '0);

    // The mode can only be switched while the buffer holds nothing, so the
    // pointer bookkeeping of one mode never has to interpret the other's data.
    assign mode_eff = empty ? mode : mode_q;
    assign lifo     = ~mode_eff;
    assign top_addr = wr_ptr - 1'b1;

    // Outside of empty, mode_eff equals mode_q, so the read side follows the
    // locked mode.
    always_comb begin
        r_data = '0;
        if (!empty) begin
            r_data = mode_q ? mem[rd_ptr] : mem[top_addr];
        end
    end

    always_comb begin
        wr_ptr_n  = wr_ptr;
        rd_ptr_n  = rd_ptr;
        count_n   = count;
        err_ovf_n = err_ovf;
        err_unf_n = err_unf;
        we        = 1'b0;
        waddr     = wr_ptr;

        if (clear) begin
            wr_ptr_n  = '0;
            rd_ptr_n  = '0;
            count_n   = '0;
            err_ovf_n = 1'b0;
            err_unf_n = 1'b0;
        end else begin
            unique case ({push, pop})
                2'b10: begin
                    if (!full) begin
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        count_n  = count + 1'b1;
                    end else begin
                        err_ovf_n = 1'b1;
                    end
                end
                2'b01: begin
                    if (!empty) begin
                        if (lifo) begin
                            wr_ptr_n = wr_ptr - 1'b1;
                        end else begin
                            rd_ptr_n = rd_ptr + 1'b1;
                        end
                        count_n = count - 1'b1;
                    end else begin
                        err_unf_n = 1'b1;
                    end
                end
                2'b11: begin
                    if (empty) begin
                        // Nothing to pop: the push still goes in.
                        we        = 1'b1;
                        wr_ptr_n  = wr_ptr + 1'b1;
                        count_n   = count + 1'b1;
                        err_unf_n = 1'b1;
                    end else if (lifo) begin
                        // Replace the top word in place.
                        we    = 1'b1;
                        waddr = top_addr;
                    end else begin
                        // When full, wr_ptr == rd_ptr: the outgoing head slot
                        // is reused for the incoming tail word.
                        we       = 1'b1;
                        wr_ptr_n = wr_ptr + 1'b1;
                        rd_ptr_n = rd_ptr + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            mode_q  <= 1'b0;
            err_ovf <= 1'b0;
            err_unf <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_n;
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            mode_q  <= mode_eff;
            err_ovf <= err_ovf_n;
            err_unf <= err_unf_n;
        end
    end

    // Storage is intentionally left out of reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= w_data;
        end
    end

endmodule
